// File: rtl/input_manager_pkg.sv
// Shared constants for the input manager: default debounce/DAS/ARR timing
// and the repeat FSM state encoding.
`ifndef IM_DEBOUNCE_CYCLES
`define IM_DEBOUNCE_CYCLES 250000
`endif
`ifndef IM_DAS_FRAMES
`define IM_DAS_FRAMES 16
`endif
`ifndef IM_ARR_FRAMES
`define IM_ARR_FRAMES 6
`endif
`ifndef IM_DOWN_ARR_FRAMES
`define IM_DOWN_ARR_FRAMES 3
`endif

package input_manager_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = `IM_DEBOUNCE_CYCLES;
  localparam int DAS_FRAMES_DEF      = `IM_DAS_FRAMES;
  localparam int ARR_FRAMES_DEF      = `IM_ARR_FRAMES;
  localparam int DOWN_ARR_FRAMES_DEF = `IM_DOWN_ARR_FRAMES;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

endpackage

// File: rtl/input_manager_key_repeat.sv
// One button channel: 2-flop synchronizer, debouncer and an optional
// DAS/ARR auto-repeat FSM producing single-clk command pulses.
module key_repeat
  import input_manager_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int FIRST_FRAMES    = DAS_FRAMES_DEF,
  parameter int ARR_FRAMES      = ARR_FRAMES_DEF,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_i,
  input  logic force_idle_i,
  output logic level_o,
  output logic key_o
);

  localparam int DB_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] FIRST_LAST = 8'(FIRST_FRAMES - 1);
  localparam logic [7:0] ARR_LAST   = 8'(ARR_FRAMES - 1);

  logic [1:0]      sync_q;
  logic            lvl_q, lvl_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]      st_q, st_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            key_q, key_d;
  logic            tick_cnt;

  assign level_o  = lvl_q;
  assign key_o    = key_q;
  assign tick_cnt = REPEAT_EN && tick_i;

  // Debounce: flip the level after DEBOUNCE_CYCLES disagreeing samples.
  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = '0;
    if (sync_q[1] != lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        lvl_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Repeat FSM: press pulse, then DAS delay, then ARR repeats.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    key_d = 1'b0;
    if (!lvl_q || force_idle_i) begin
      st_d  = ST_IDLE;
      cnt_d = '0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          key_d = 1'b1;
          st_d  = ST_DELAY;
          cnt_d = '0;
        end
        ST_DELAY: begin
          if (tick_cnt) begin
            if (cnt_q == FIRST_LAST) begin
              key_d = 1'b1;
              cnt_d = '0;
              st_d  = ST_REPEAT;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_REPEAT: begin
          if (tick_cnt) begin
            if (cnt_q == ARR_LAST) begin
              key_d = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      lvl_q    <= 1'b0;
      db_cnt_q <= '0;
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
      key_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      lvl_q    <= lvl_d;
      db_cnt_q <= db_cnt_d;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
    end
  end

endmodule

// File: rtl/input_manager.sv
// Five-button input front end: debounced, auto-repeating command pulses
// with left/right mutual suppression.
module input_manager
  import input_manager_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DAS_FRAMES      = DAS_FRAMES_DEF,
  parameter int ARR_FRAMES      = ARR_FRAMES_DEF,
  parameter int DOWN_ARR_FRAMES = DOWN_ARR_FRAMES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_game,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_rotate,
  input  logic btn_drop,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate,
  output logic key_drop
);

  logic [4:0] lvl;
  logic       lr_both;
  logic       unused_lvl;

  // Holding left and right together cancels both directions.
  assign lr_both    = lvl[0] & lvl[1];
  assign unused_lvl = ^lvl[4:2];

  key_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .FIRST_FRAMES   (DAS_FRAMES),
    .ARR_FRAMES     (ARR_FRAMES),
    .REPEAT_EN      (1'b1)
  ) u_left (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_i      (tick_game),
    .btn_i       (btn_left),
    .force_idle_i(lr_both),
    .level_o     (lvl[0]),
    .key_o       (key_left)
  );

  key_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .FIRST_FRAMES   (DAS_FRAMES),
    .ARR_FRAMES     (ARR_FRAMES),
    .REPEAT_EN      (1'b1)
  ) u_right (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_i      (tick_game),
    .btn_i       (btn_right),
    .force_idle_i(lr_both),
    .level_o     (lvl[1]),
    .key_o       (key_right)
  );

  key_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .FIRST_FRAMES   (DOWN_ARR_FRAMES),
    .ARR_FRAMES     (DOWN_ARR_FRAMES),
    .REPEAT_EN      (1'b1)
  ) u_down (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_i      (tick_game),
    .btn_i       (btn_down),
    .force_idle_i(1'b0),
    .level_o     (lvl[2]),
    .key_o       (key_down)
  );

  key_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .FIRST_FRAMES   (DAS_FRAMES),
    .ARR_FRAMES     (ARR_FRAMES),
    .REPEAT_EN      (1'b0)
  ) u_rotate (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_i      (tick_game),
    .btn_i       (btn_rotate),
    .force_idle_i(1'b0),
    .level_o     (lvl[3]),
    .key_o       (key_rotate)
  );

  key_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .FIRST_FRAMES   (DAS_FRAMES),
    .ARR_FRAMES     (ARR_FRAMES),
    .REPEAT_EN      (1'b0)
  ) u_drop (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_i      (tick_game),
    .btn_i       (btn_drop),
    .force_idle_i(1'b0),
    .level_o     (lvl[4]),
    .key_o       (key_drop)
  );

endmodule

// File: tb/tb_input_manager.sv
// Bench for input_manager: directed scenarios plus random button activity,
// all checked every cycle against a tick-counting reference model.
module tb_input_manager;

  localparam int D   = 4;
  localparam int DAS = 3;
  localparam int ARR = 2;
  localparam int DN  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_game = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic btn_down = 1'b0;
  logic btn_rotate = 1'b0;
  logic btn_drop = 1'b0;
  logic key_left, key_right, key_down, key_rotate, key_drop;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int pcount[5];
  int plast[5];

  input_manager #(
    .DEBOUNCE_CYCLES(D),
    .DAS_FRAMES     (DAS),
    .ARR_FRAMES     (ARR),
    .DOWN_ARR_FRAMES(DN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_game (tick_game),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_rotate(btn_rotate),
    .btn_drop  (btn_drop),
    .key_left  (key_left),
    .key_right (key_right),
    .key_down  (key_down),
    .key_rotate(key_rotate),
    .key_drop  (key_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int b);
    case (b)
      0: return "key_left";
      1: return "key_right";
      2: return "key_down";
      3: return "key_rotate";
      default: return "key_drop";
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // 60 Hz stand-in: tick high in the cycle after every edge with cyc%10==0
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_game = (cyc % 10 == 0);
    end
  end

  // Reference model and per-cycle comparison
  initial begin : model
    logic raw[5];
    logic rn, tk_in, eff, p, sup, alld;
    logic hist[5][8];
    logic lvl[5], lo[5], effp[5], expk[5], act[5];
    int   tk[5];
    int   first, arr;
    for (int b = 0; b < 5; b++) begin
      lvl[b] = 0; effp[b] = 0; expk[b] = 0; tk[b] = 0;
      pcount[b] = 0; plast[b] = -1000;
      for (int i = 0; i < 8; i++) hist[b][i] = 0;
    end
    forever begin
      @(posedge clk);
      raw[0] = btn_left;
      raw[1] = btn_right;
      raw[2] = btn_down;
      raw[3] = btn_rotate;
      raw[4] = btn_drop;
      rn = rst_n;
      tk_in = tick_game;
      if (!rn) begin
        for (int b = 0; b < 5; b++) begin
          lvl[b] = 0; effp[b] = 0; expk[b] = 0; tk[b] = 0;
          for (int i = 0; i < 8; i++) hist[b][i] = 0;
        end
      end else begin
        for (int b = 0; b < 5; b++) lo[b] = lvl[b];
        sup = lo[0] & lo[1];
        for (int b = 0; b < 5; b++) begin
          eff = lo[b] && !(b < 2 && sup);
          p = 0;
          if (eff && !effp[b]) begin
            p = 1;
            tk[b] = 0;
          end else if (eff && tk_in && b < 3) begin
            tk[b]++;
            first = (b == 2) ? DN : DAS;
            arr   = (b == 2) ? DN : ARR;
            if (tk[b] == first) p = 1;
            if (tk[b] > first && (tk[b] - first) % arr == 0) p = 1;
          end
          if (!eff) tk[b] = 0;
          effp[b] = eff;
          expk[b] = p;
        end
        // sample at this edge is raw from two edges ago (hist[1])
        for (int b = 0; b < 5; b++) begin
          alld = 1;
          for (int i = 1; i <= D; i++)
            if (hist[b][i] == lo[b]) alld = 0;
          if (alld) lvl[b] = ~lo[b];
          for (int i = 7; i > 0; i--) hist[b][i] = hist[b][i-1];
          hist[b][0] = raw[b];
        end
      end
      @(negedge clk);
      act[0] = key_left;
      act[1] = key_right;
      act[2] = key_down;
      act[3] = key_rotate;
      act[4] = key_drop;
      for (int b = 0; b < 5; b++) begin
        vectors++;
        if (act[b] !== expk[b]) begin
          miscompares++;
          $display("FAIL %s cyc=%0d: got %b, expected %b",
                   kname(b), cyc, act[b], expk[b]);
        end
        if (act[b] === 1'b1) begin
          pcount[b]++;
          plast[b] = cyc;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int c0, hs, n0, n1, sl, sr, rel, rr;
    rst_n = 0;
    step(3);
    check("reset_keys",
          int'({key_left, key_right, key_down, key_rotate, key_drop}), 0);
    rst_n = 1;
    step(5);

    // rotate: single pulse, 7 clk after raw rise, no repeat
    c0 = cyc; n0 = pcount[3];
    btn_rotate = 1;
    step(10);
    check("rot_latency", plast[3] - c0, 7);
    step(190);
    check("rot_once", pcount[3] - n0, 1);
    btn_rotate = 0;
    step(20);

    // left with bounce, then 100 clk hold
    n0 = pcount[0];
    btn_left = 1; step(1);
    btn_left = 0; step(1);
    btn_left = 1; step(1);
    btn_left = 0; step(1);
    hs = cyc;
    btn_left = 1;
    step(10);
    check("left_press_lat", plast[0] - hs, 7);
    check("left_no_bounce_pulse", pcount[0] - n0, 1);
    step(90);
    btn_left = 0;
    step(20);
    check("left_pulses", pcount[0] - n0, 5);

    // down held for exactly 5 counted ticks
    while (cyc % 10 != 0) step(1);
    n0 = pcount[2];
    btn_down = 1;
    step(50);
    btn_down = 0;
    step(20);
    check("down_pulses", pcount[2] - n0, 6);

    // left held, then right: mutual suppression, then fresh right press
    btn_left = 1;
    step(40);
    btn_right = 1;
    step(7);
    sl = pcount[0]; sr = pcount[1];
    step(60);
    check("both_left", pcount[0] - sl, 0);
    check("both_right", pcount[1] - sr, 0);
    rel = cyc;
    btn_left = 0;
    step(10);
    check("right_fresh_lat", plast[1] - rel, 7);
    check("right_fresh_cnt", pcount[1] - sr, 1);
    step(40);
    btn_right = 0;
    step(20);

    // reset mid-hold: drop and left held through a 2-clk reset
    btn_drop = 1; btn_left = 1;
    step(25);
    n1 = pcount[4];
    rst_n = 0;
    step(1);
    check("rst_keys_a",
          int'({key_left, key_right, key_down, key_rotate, key_drop}), 0);
    step(1);
    check("rst_keys_b",
          int'({key_left, key_right, key_down, key_rotate, key_drop}), 0);
    rst_n = 1;
    rr = cyc;
    step(10);
    check("drop_after_rst", plast[4] - rr, 7);
    check("drop_rst_cnt", pcount[4] - n1, 1);
    step(30);
    btn_drop = 0; btn_left = 0;
    step(20);

    // left released mid-DAS after 2 ticks, re-pressed: DAS restarts
    while (cyc % 10 != 0) step(1);
    c0 = cyc;
    btn_left = 1;
    step(22);
    btn_left = 0;
    step(8);
    n0 = pcount[0];
    btn_left = 1;
    step(30);
    check("das_restart_nostale", pcount[0] - n0, 1);
    step(2);
    check("das_restart_rep", plast[0] - c0, 61);
    check("das_restart_cnt", pcount[0] - n0, 2);
    btn_left = 0;
    step(20);

    // random activity on all buttons, occasional short resets
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 3) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 3) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 3) == 0) btn_rotate = ~btn_rotate;
      if ($urandom_range(0, 3) == 0) btn_drop = ~btn_drop;
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 0;
        step($urandom_range(1, 3));
        rst_n = 1;
      end
      step($urandom_range(1, 30));
    end
    btn_left = 0; btn_right = 0; btn_down = 0;
    btn_rotate = 0; btn_drop = 0;
    step(30);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
